// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the MAC operand sequencer.
package mac_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } mac_seq_state_t;

    localparam int OP_W_DFLT  = 4;
    localparam int ACC_W_DFLT = 8;
    localparam int SHADOW_W   = 11;

endpackage

// File: rtl/mac_seq_buf.sv
// Operand-pair register file with write/read pointers and fill count.
module mac_seq_buf #(
    parameter int DEPTH = 8,
    parameter int W     = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [W-1:0]     wr_data,
    input  logic             rd_en,
    input  logic             clr,
    output logic [W-1:0]     rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= wr_data;
    end

    // count tracks loaded pairs only; streaming reads do not consume it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                count  <= count + 1'b1;
            end
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/mac_operand_sequencer.sv
// Loads operand pairs, streams them into the MAC on start and presents the sum.
// Optional overflow detection: define MAC_SEQ_OVF_DETECT_EN.
//   state  | meaning
//   IDLE   | accept loads, wait for start
//   CLEAR  | pulse mac_clr
//   STREAM | drive one buffered pair per cycle
//   DRAIN  | MAC holds final sum, capture it
//   DONE   | hold result until result_ready
module mac_operand_sequencer
    import mac_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int OP_W  = OP_W_DFLT,
    parameter int ACC_W = ACC_W_DFLT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*OP_W-1:0] in_data,
    input  logic              start,
    output logic [OP_W-1:0]   mac_a,
    output logic [OP_W-1:0]   mac_b,
    output logic              mac_clr,
    input  logic [ACC_W-1:0]  mac_acc,
    output logic [ACC_W-1:0]  result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              busy,
    output logic              ovf
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    mac_seq_state_t    state, state_nxt;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  rem;
    logic [2*OP_W-1:0] rd_data;
    logic              full, empty;
    logic              wr_en, issue, buf_clr, start_go;

    assign in_ready = (state == S_IDLE) && !full && !start;
    assign wr_en    = in_valid && in_ready;
    assign start_go = (state == S_IDLE) && start;
    assign issue    = (state_nxt == S_STREAM);
    assign buf_clr  = (state == S_DONE) && result_ready;

    mac_seq_buf #(.DEPTH(DEPTH), .W(2*OP_W)) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (in_data),
        .rd_en   (issue),
        .clr     (buf_clr),
        .rd_data (rd_data),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // rem counts pairs still to be issued; STREAM ends at its terminal count
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = empty ? S_DONE : S_CLEAR;
            S_CLEAR:  state_nxt = S_STREAM;
            S_STREAM: if (rem == '0) state_nxt = S_DRAIN;
            S_DRAIN:  state_nxt = S_DONE;
            S_DONE:   if (result_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_a        <= '0;
            mac_b        <= '0;
            mac_clr      <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
            rem          <= '0;
        end else begin
            mac_clr      <= (state_nxt == S_CLEAR);
            mac_a        <= issue ? rd_data[OP_W-1:0]      : '0;
            mac_b        <= issue ? rd_data[2*OP_W-1:OP_W] : '0;
            busy         <= (state_nxt != S_IDLE);
            result_valid <= (state_nxt == S_DONE);
            if (start_go)
                rem <= count;
            else if (issue)
                rem <= rem - 1'b1;
            if (start_go && empty)
                result <= '0;
            else if (state == S_DRAIN)
                result <= mac_acc;
        end
    end

`ifdef MAC_SEQ_OVF_DETECT_EN
    localparam logic [SHADOW_W-1:0] ACC_MAX   = SHADOW_W'((1 << ACC_W) - 1);
    localparam logic [SHADOW_W:0]   SHADOW_SAT = {1'b0, {SHADOW_W{1'b1}}};

    logic [SHADOW_W-1:0] shadow;
    logic [SHADOW_W:0]   a_ext, b_ext, shadow_sum;
    logic                ovf_q;

    assign a_ext      = (SHADOW_W+1)'(mac_a);
    assign b_ext      = (SHADOW_W+1)'(mac_b);
    assign shadow_sum = {1'b0, shadow} + a_ext * b_ext;

    // Saturate so deep buffers of large operands still read as overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (state_nxt == S_CLEAR)
                shadow <= '0;
            else if (state == S_STREAM)
                shadow <= shadow_sum[SHADOW_W] ? SHADOW_SAT[SHADOW_W-1:0]
                                               : shadow_sum[SHADOW_W-1:0];
            if (start_go && empty)
                ovf_q <= 1'b0;
            else if (state == S_DRAIN)
                ovf_q <= (shadow > ACC_MAX);
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule
